// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the SRAM memory-stage controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_BASE_ADDR = 1024;
  localparam int          DEF_SRAM_AW   = 18;

  // Half-word select appended as the SRAM address LSB.
  localparam logic HALF_LOW  = 1'b0;
  localparam logic HALF_HIGH = 1'b1;

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline-side request bus and SRAM pad signals of the memory-stage controller.
interface sram_controller_if #(
  parameter int SRAM_AW = 18
);
  // Handshake: wr_en/rd_en are levels held by the frozen pipeline. The controller
  // accepts only in IDLE and keeps ready low until DONE. The access retires on the
  // clock edge that ends the cycle with ready high. A request still asserted in the
  // following IDLE cycle starts a new access.
  logic               wr_en;
  logic               rd_en;
  logic [31:0]        address;
  logic [31:0]        write_data;
  logic [31:0]        read_data;
  logic               ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_out;
  logic               sram_dq_oe;
  logic [15:0]        sram_dq_in;
  logic               sram_we_n;

  modport slave (
    input  wr_en, rd_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport master (
    output wr_en, rd_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_controller_phase_timer.sv
// Loadable down-counter that times one half-word phase; last_o marks its final cycle.
module sram_phase_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          last_o,
  output logic          last_d_o
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o   = (count_q == '0);
  // Lets the owner register strobes that depend on next cycle's phase position.
  assign last_d_o = (count_d == '0);

endmodule

// File: rtl/sram_controller.sv
// Memory-stage controller: splits 32-bit accesses into two half-word SRAM phases.
// Optional address range check is enabled by defining SRAM_CTRL_ADDR_CHECK_EN.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int          WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = 32'(DEF_BASE_ADDR),
  parameter int          SRAM_AW     = DEF_SRAM_AW
) (
  input  logic              clk,
  input  logic              rst,
  sram_controller_if.slave  bus,
  output state_e            dbg_state_o
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int WW = SRAM_AW - 1;

  state_e             state_q, state_d;
  logic               wr_q, wr_d;
  logic [WW-1:0]      word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [15:0]        rlo_q, rlo_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [15:0]        dq_q, dq_d;
  logic               oe_q, oe_d;
  logic               we_n_q, we_n_d;
  logic               ready;
  logic               half;
  logic               req;
  logic               addr_bad;
  logic               timer_load;
  logic               phase_last;
  logic               phase_last_d;
  logic [31:0]        eff;
  logic               unused_eff_bits;

  assign req = bus.wr_en | bus.rd_en;
  assign eff = bus.address - BASE_ADDR;
  assign unused_eff_bits = ^{eff[31:SRAM_AW+1], eff[1:0]};

`ifdef SRAM_CTRL_ADDR_CHECK_EN
  assign addr_bad = (bus.address < BASE_ADDR) || (eff[31:SRAM_AW+1] != '0);
`else
  assign addr_bad = 1'b0;
`endif

  sram_phase_timer #(.CW(CW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (CW'(WAIT_CYCLES - 1)),
    .last_o     (phase_last),
    .last_d_o   (phase_last_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    word_d     = word_q;
    wdata_d    = wdata_q;
    timer_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          wr_d    = bus.wr_en;
          word_d  = eff[SRAM_AW:2];
          wdata_d = bus.write_data;
          if (addr_bad) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_LOW;
            timer_load = 1'b1;
          end
        end
      end
      ST_LOW: begin
        if (phase_last) begin
          state_d    = ST_HIGH;
          timer_load = 1'b1;
        end
      end
      ST_HIGH: begin
        if (phase_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pad outputs are computed for the upcoming cycle and registered, so nothing
  // combinational reaches the pins. we_n releases on each phase's final cycle.
  always_comb begin
    addr_d  = addr_q;
    dq_d    = dq_q;
    oe_d    = 1'b0;
    we_n_d  = 1'b1;
    rlo_d   = rlo_q;
    rdata_d = rdata_q;
    half    = (state_d == ST_HIGH) ? HALF_HIGH : HALF_LOW;
    if (state_d == ST_LOW || state_d == ST_HIGH) begin
      addr_d = {word_d, half};
      oe_d   = wr_d;
      we_n_d = ~(wr_d & ~phase_last_d);
      if (wr_d) begin
        dq_d = (half == HALF_HIGH) ? wdata_d[31:16] : wdata_d[15:0];
      end else begin
        dq_d = 16'h0000;
      end
    end
    if (state_q == ST_LOW && phase_last && !wr_q) rlo_d = bus.sram_dq_in;
    if (state_q == ST_HIGH && phase_last && !wr_q) rdata_d = {bus.sram_dq_in, rlo_q};
    if (state_q == ST_IDLE && state_d == ST_DONE && !wr_d) rdata_d = '0;
    ready = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rlo_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rlo_q   <= rlo_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
      we_n_q  <= we_n_d;
    end
  end

  assign bus.read_data   = rdata_q;
  assign bus.ready       = ready;
  assign bus.sram_addr   = addr_q;
  assign bus.sram_dq_out = dq_q;
  assign bus.sram_dq_oe  = oe_q;
  assign bus.sram_we_n   = we_n_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 16-bit async SRAM.
module tb_sram_controller;
  import sram_ctrl_pkg::*;

  logic   clk;
  logic   rst;
  state_e dbg_state;
  int     total;
  int     bad;

  logic [15:0] mem [logic [17:0]];

  sram_controller_if #(.SRAM_AW(18)) bus ();

  sram_controller #(
    .WAIT_CYCLES (3),
    .BASE_ADDR   (32'd1024),
    .SRAM_AW     (18)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // SRAM model: latches data on the rising edge of the write strobe
  always @(posedge bus.sram_we_n) begin
    if (rst) mem[bus.sram_addr] = bus.sram_dq_out;
  end

  always @(negedge clk) begin
    bus.sram_dq_in = mem.exists(bus.sram_addr) ? mem[bus.sram_addr] : 16'h0000;
  end

  // driver: issue one request, hold it until ready, then drop it
  task automatic run_access(input logic wr, input logic rd, input logic [31:0] a,
                            input logic [31:0] d, output int rcyc,
                            output logic [31:0] rdata, output logic [17:0] addr1,
                            output int we_lo, output int oe_hi);
    @(negedge clk);
    bus.wr_en = wr; bus.rd_en = rd; bus.address = a; bus.write_data = d;
    rcyc = -1; rdata = '0; addr1 = '0; we_lo = 0; oe_hi = 0;
    for (int c = 1; c <= 20 && rcyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) addr1 = bus.sram_addr;
      if (!bus.sram_we_n) we_lo++;
      if (bus.sram_dq_oe) oe_hi++;
      if (bus.ready) begin
        rcyc  = c;
        rdata = bus.read_data;
      end
    end
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = '0; bus.write_data = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.ready, bus.sram_we_n, bus.sram_dq_oe, bus.sram_addr, bus.sram_dq_out,
         bus.read_data, dbg_state} !== {1'b1, 1'b1, 1'b0, 18'h0, 16'h0, 32'h0, ST_IDLE}) begin
      bad++;
      $display("FAIL reset_values rdy=%b we_n=%b oe=%b addr=%h dq=%h rd=%h st=%0d",
               bus.ready, bus.sram_we_n, bus.sram_dq_oe, bus.sram_addr,
               bus.sram_dq_out, bus.read_data, dbg_state);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.ready, dbg_state} !== {1'b1, ST_IDLE}) begin
      bad++;
      $display("FAIL reset_release rdy=%b st=%0d exp rdy=1 st=IDLE", bus.ready, dbg_state);
    end
  endtask

  task automatic test_write();
    logic [36:0] got, exp;
    @(negedge clk);
    bus.wr_en = 1'b1; bus.address = 32'd1028; bus.write_data = 32'hDEADBEEF;
    #1;
    total++;
    if (bus.ready !== 1'b0) begin
      bad++;
      $display("FAIL write_c0_ready got=%b exp=0", bus.ready);
    end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      got = {bus.ready, bus.sram_we_n, bus.sram_dq_oe, bus.sram_addr, bus.sram_dq_out};
      exp = {1'b0, (c == 3 || c == 6), 1'b1, (c <= 3) ? 18'd2 : 18'd3,
             (c <= 3) ? 16'hBEEF : 16'hDEAD};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL write_c%0d got=%h exp=%h", c, got, exp);
      end
    end
    @(negedge clk);
    total++;
    if ({bus.ready, bus.sram_we_n, bus.sram_dq_oe, dbg_state} !== {1'b1, 1'b1, 1'b0, ST_DONE}) begin
      bad++;
      $display("FAIL write_done rdy=%b we_n=%b oe=%b st=%0d", bus.ready, bus.sram_we_n,
               bus.sram_dq_oe, dbg_state);
    end
    bus.wr_en = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.ready, dbg_state} !== {1'b1, ST_IDLE}) begin
      bad++;
      $display("FAIL write_after rdy=%b st=%0d exp rdy=1 st=IDLE", bus.ready, dbg_state);
    end
  endtask

  task automatic test_read();
    logic [36:0] got, exp;
    @(negedge clk);
    bus.rd_en = 1'b1; bus.address = 32'd1028;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      got = {bus.ready, bus.sram_we_n, bus.sram_dq_oe, bus.sram_addr, 16'h0};
      exp = {1'b0, 1'b1, 1'b0, (c <= 3) ? 18'd2 : 18'd3, 16'h0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL read_c%0d got=%h exp=%h", c, got, exp);
      end
    end
    total++;
    if (bus.read_data !== 32'h0) begin
      bad++;
      $display("FAIL read_early got=%h exp=00000000", bus.read_data);
    end
    @(negedge clk);
    total++;
    if ({bus.ready, bus.sram_dq_oe, bus.read_data} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL read_done rdy=%b oe=%b rd=%h exp rdy=1 oe=0 rd=deadbeef",
               bus.ready, bus.sram_dq_oe, bus.read_data);
    end
    bus.rd_en = 1'b0;
    @(negedge clk);
    total++;
    if ({dbg_state, bus.read_data} !== {ST_IDLE, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL read_hold st=%0d rd=%h exp IDLE deadbeef", dbg_state, bus.read_data);
    end
  endtask

  task automatic test_both();
    int rcyc, we_lo, oe_hi;
    logic [31:0] rdata;
    logic [17:0] addr1;
    run_access(1'b1, 1'b1, 32'd1032, 32'h12345678, rcyc, rdata, addr1, we_lo, oe_hi);
    total++;
    if ({rcyc, we_lo, oe_hi, addr1, rdata} !== {32'd7, 32'd4, 32'd6, 18'd4, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL both_as_write rcyc=%0d we_lo=%0d oe=%0d addr=%h rd=%h exp 7 4 6 4 deadbeef",
               rcyc, we_lo, oe_hi, addr1, rdata);
    end
    run_access(1'b0, 1'b1, 32'd1032, 32'h0, rcyc, rdata, addr1, we_lo, oe_hi);
    total++;
    if ({rcyc, we_lo, oe_hi, rdata} !== {32'd7, 32'd0, 32'd0, 32'h12345678}) begin
      bad++;
      $display("FAIL both_readback rcyc=%0d we_lo=%0d oe=%0d rd=%h exp 7 0 0 12345678",
               rcyc, we_lo, oe_hi, rdata);
    end
  endtask

  task automatic test_reset_mid();
    int rcyc, we_lo, oe_hi;
    logic [31:0] rdata;
    logic [17:0] addr1;
    @(negedge clk);
    bus.wr_en = 1'b1; bus.address = 32'd1040; bus.write_data = 32'hCAFEF00D;
    repeat (4) @(negedge clk);
    total++;
    if (dbg_state !== ST_HIGH) begin
      bad++;
      $display("FAIL rstmid_pre st=%0d exp HIGH", dbg_state);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({bus.sram_we_n, bus.sram_dq_oe, dbg_state, bus.sram_addr, bus.sram_dq_out,
         bus.read_data, bus.ready} !== {1'b1, 1'b0, ST_IDLE, 18'h0, 16'h0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL rstmid_now we_n=%b oe=%b st=%0d addr=%h dq=%h rd=%h rdy=%b",
               bus.sram_we_n, bus.sram_dq_oe, dbg_state, bus.sram_addr,
               bus.sram_dq_out, bus.read_data, bus.ready);
    end
    bus.wr_en = 1'b0;
    #1;
    total++;
    if (bus.ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_ready got=%b exp=1", bus.ready);
    end
    @(negedge clk);
    rst = 1'b1;
    run_access(1'b1, 1'b0, 32'd1040, 32'hCAFEF00D, rcyc, rdata, addr1, we_lo, oe_hi);
    total++;
    if ({rcyc, we_lo, addr1} !== {32'd7, 32'd4, 18'd8}) begin
      bad++;
      $display("FAIL rstmid_restart rcyc=%0d we_lo=%0d addr=%h exp 7 4 8", rcyc, we_lo, addr1);
    end
    run_access(1'b0, 1'b1, 32'd1040, 32'h0, rcyc, rdata, addr1, we_lo, oe_hi);
    total++;
    if ({rcyc, rdata} !== {32'd7, 32'hCAFEF00D}) begin
      bad++;
      $display("FAIL rstmid_readback rcyc=%0d rd=%h exp 7 cafef00d", rcyc, rdata);
    end
  endtask

  task automatic test_drop();
    @(negedge clk);
    bus.rd_en = 1'b1; bus.address = 32'd1028;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2) bus.rd_en = 1'b0;
      total++;
      if (bus.ready !== 1'b0) begin
        bad++;
        $display("FAIL drop_c%0d ready got=%b exp=0", c, bus.ready);
      end
    end
    @(negedge clk);
    total++;
    if ({bus.ready, dbg_state, bus.read_data} !== {1'b1, ST_DONE, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL drop_done rdy=%b st=%0d rd=%h exp 1 DONE deadbeef",
               bus.ready, dbg_state, bus.read_data);
    end
    for (int c = 8; c <= 9; c++) begin
      @(negedge clk);
      total++;
      if ({bus.ready, dbg_state} !== {1'b1, ST_IDLE}) begin
        bad++;
        $display("FAIL drop_c%0d rdy=%b st=%0d exp 1 IDLE", c, bus.ready, dbg_state);
      end
    end
  endtask

  task automatic test_addr_range();
    int rcyc, we_lo, oe_hi;
    logic [31:0] rdata;
    logic [17:0] addr1;
    run_access(1'b0, 1'b1, 32'd1024, 32'h0, rcyc, rdata, addr1, we_lo, oe_hi);
    total++;
    if ({rcyc, addr1} !== {32'd7, 18'h0}) begin
      bad++;
      $display("FAIL range_base rcyc=%0d addr=%h exp 7 0", rcyc, addr1);
    end
    run_access(1'b0, 1'b1, 32'd525308, 32'h0, rcyc, rdata, addr1, we_lo, oe_hi);
    total++;
    if ({rcyc, addr1} !== {32'd7, 18'h3FFFE}) begin
      bad++;
      $display("FAIL range_top rcyc=%0d addr=%h exp 7 3fffe", rcyc, addr1);
    end
    run_access(1'b0, 1'b1, 32'd1028, 32'h0, rcyc, rdata, addr1, we_lo, oe_hi);
    total++;
    if (rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL range_prime rd=%h exp deadbeef", rdata);
    end
`ifdef SRAM_CTRL_ADDR_CHECK_EN
    run_access(1'b0, 1'b1, 32'd512, 32'h0, rcyc, rdata, addr1, we_lo, oe_hi);
    total++;
    if ({rcyc, rdata, we_lo, oe_hi} !== {32'd1, 32'h0, 32'd0, 32'd0}) begin
      bad++;
      $display("FAIL range_low rcyc=%0d rd=%h we_lo=%0d oe=%0d exp 1 0 0 0",
               rcyc, rdata, we_lo, oe_hi);
    end
    run_access(1'b1, 1'b0, 32'd525312, 32'h55AA55AA, rcyc, rdata, addr1, we_lo, oe_hi);
    total++;
    if ({rcyc, we_lo, oe_hi} !== {32'd1, 32'd0, 32'd0}) begin
      bad++;
      $display("FAIL range_high rcyc=%0d we_lo=%0d oe=%0d exp 1 0 0", rcyc, we_lo, oe_hi);
    end
`else
    run_access(1'b0, 1'b1, 32'd512, 32'h0, rcyc, rdata, addr1, we_lo, oe_hi);
    total++;
    if ({rcyc, addr1} !== {32'd7, 18'h3FF00}) begin
      bad++;
      $display("FAIL range_low_wrap rcyc=%0d addr=%h exp 7 3ff00", rcyc, addr1);
    end
    run_access(1'b1, 1'b0, 32'd525312, 32'h55AA55AA, rcyc, rdata, addr1, we_lo, oe_hi);
    total++;
    if ({rcyc, addr1, we_lo} !== {32'd7, 18'h0, 32'd4}) begin
      bad++;
      $display("FAIL range_high_wrap rcyc=%0d addr=%h we_lo=%0d exp 7 0 4", rcyc, addr1, we_lo);
    end
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write();
    test_read();
    test_both();
    test_reset_mid();
    test_drop();
    test_addr_range();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage controller that turns the execute stage's address result and memory enables into multi-cycle accesses on an external 16-bit asynchronous SRAM. Each 32-bit word access is split into two half-word phases with programmable wait states. While an access is in flight it drops `ready`, and the pipeline freezes on `~ready`. On reads it returns the assembled 32-bit word to the write-back path.

## Interface
Parameters:
- `WAIT_CYCLES`, 3: cycles held per half-word phase (≥1).
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `SRAM_AW`, 18: SRAM half-word address width.

Ports:
- `clk` in 1: single clock; all state is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `wr_en` in 1: store request; level, held by the frozen pipeline.
- `rd_en` in 1: load request; level.
- `address` in 32: byte address from the ALU result.
- `write_data` in 32: store data (forwarded Rm value).
- `read_data` out 32: loaded word.
- `ready` out 1: high means no access pending or access completing this cycle.
- `sram_addr` out SRAM_AW: SRAM half-word address.
- `sram_dq_out` out 16: write data to the pad.
- `sram_dq_oe` out 1: pad output enable.
- `sram_dq_in` in 16: read data from the pad.
- `sram_we_n` out 1: SRAM write strobe, active-low.

## Operation
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE: on `wr_en|rd_en`, latch the op (write wins if both are high), the address and write_data, then go to LOW.
- LOW: drive the low half-word; HIGH: drive the high half-word. Each phase lasts WAIT_CYCLES cycles, timed by a down-counter. LOW→HIGH and HIGH→DONE occur on the last cycle of the phase.
- DONE: one cycle, then IDLE. A new request is accepted only from IDLE, so there are no back-to-back accepts in DONE.
- Address mapping:
  - eff = address − BASE_ADDR, 32-bit wrap.
  - word = eff[SRAM_AW:2].
  - LOW uses `sram_addr` = {word,0}; HIGH uses {word,1}.
  - eff[1:0] is ignored.
- Write:
  - `sram_dq_oe`=1 through both phases.
  - `sram_dq_out` = wdata[15:0] in LOW and wdata[31:16] in HIGH.
  - `sram_we_n`=0 on every phase cycle except the last one of each phase, giving a data/address hold edge.
- Read:
  - `sram_dq_oe`=0 and `sram_we_n`=1.
  - `sram_dq_in` is sampled on the last cycle of LOW into [15:0] and of HIGH into [31:16].
  - `read_data` updates on entry to DONE and holds until the next read completes. Writes do not alter it.
- `ready` = (IDLE & ~(wr_en|rd_en)) | DONE, combinational from registered state.
- Request deasserted mid-access: the access still completes and `ready` stays low until DONE. There is no abort.

## Timing
- Reset values: state IDLE, `read_data`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1, `ready`=1 (no request).
- Reset mid-access: outputs return to reset values immediately. The partial SRAM write is abandoned.
- Request seen at cycle 0 in IDLE: `ready` is low for cycles 0..2·WAIT_CYCLES and high at cycle 2·WAIT_CYCLES+1 (DONE). With WAIT_CYCLES=3, `ready` is low for 7 cycles and high at cycle 7.
- Read data valid from the DONE cycle onward. The pipeline register captures it on the DONE edge.
- All SRAM outputs are registered, with no combinational path from `address` to the pads.

## Configuration
- `SRAM_CTRL_ADDR_CHECK_EN` defined:
  - An access with address < BASE_ADDR, or eff ≥ 2^(SRAM_AW+1), skips LOW/HIGH and goes IDLE→DONE.
  - No SRAM strobe is issued, and a read returns 0.
- Undefined: no check. The address wraps modulo SRAM size via truncation of eff.

## Structure
- Package `sram_ctrl_pkg` holds:
  - the state enum (IDLE/LOW/HIGH/DONE);
  - default constants for BASE_ADDR and SRAM_AW;
  - a half-select localparam (LOW=0, HIGH=1).
- Sub-module `sram_phase_timer`: loadable down-counter with a `last` flag. The FSM loads it with WAIT_CYCLES−1 on each phase entry.

## Test plan
- Write: `wr_en`=1, `address`=1028, `write_data`=0xDEADBEEF → `sram_addr` 2 with dq 0xBEEF, then 3 with dq 0xDEAD; `sram_we_n` low 2 cycles per phase; `ready` high at cycle 7.
- Read back with the SRAM model at 1028: `rd_en`=1 → `read_data`=0xDEADBEEF at cycle 7; `sram_dq_oe`=0 throughout.
- Both `rd_en` and `wr_en` high → treated as a write; `read_data` unchanged.
- `rst` pulsed low at cycle 4 of a write → `sram_we_n`=1, `sram_dq_oe`=0, state IDLE at once; the next request restarts from LOW.
- `rd_en` dropped after cycle 1 → `ready` still low until cycle 7; one DONE cycle, then IDLE.
- With `SRAM_CTRL_ADDR_CHECK_EN`, read at address 512 → `ready` high at cycle 1, `read_data`=0, no SRAM strobe; without the macro, the same address wraps to a real access.
